// File: rtl/fsm_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
package fsm_pkg;

    localparam int          MAX_PAT_LEN = 16;
    localparam int          DEF_PAT_LEN = 4;
    localparam logic [15:0] DEF_PATTERN = 16'b1101;

    // Number of bits needed to encode states S0..Sn, i.e. $clog2(n+1).
    function automatic int st_width(input int n);
        int w;
        w = 0;
        for (int i = 1; i <= 6; i++) begin
            if (w == 0 && (1 << i) >= n + 1) begin
                w = i;
            end
        end
        return w;
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input logic [15:0] pattern, input int len, input int i);
        return pattern[4'(len - 1 - i)];
    endfunction

    // KMP transition: from state k (first k pattern bits seen), after bit b,
    // return the longest pattern prefix that is a suffix of prefix(k) followed by b.
    function automatic int kmp_next(input logic [15:0] pattern, input int len,
                                    input int k, input logic b);
        int   best;
        int   j;
        logic ok;
        logic s_bit;
        best = 0;
        for (int l = 1; l <= MAX_PAT_LEN; l++) begin
            if (l <= k + 1 && l <= len) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < l) begin
                        j     = k + 1 - l + i;
                        s_bit = (j == k) ? b : pat_bit(pattern, len, j);
                        if (s_bit != pat_bit(pattern, len, i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

    // Longest proper border of the whole pattern: the state an overlapping
    // detector falls back to once a full match has been reported.
    function automatic int border_len(input logic [15:0] pattern, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < MAX_PAT_LEN; l++) begin
            if (l < len) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < l) begin
                        if (pat_bit(pattern, len, len - l + i) != pat_bit(pattern, len, i)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = l;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter
    import fsm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Increment on inc unless already at the maximum value; never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with Mealy and Moore match outputs.
//
// Handshake: there is no ready; en acts as a valid strobe. x_in is consumed
// on every rising edge where en=1, and ignored (state held) when en=0.
module seq_detect_fsm
    import fsm_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = st_width(PAT_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x_in,
    output logic             mealy,
    output logic             moore,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state_dbg
);

    // Reject illegal pattern lengths at elaboration time.
    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $error("seq_detect_fsm: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("seq_detect_fsm: CNT_W must be at least 1");
    end

    typedef logic [SW-1:0] state_t;

    localparam logic [15:0] PAT_EXT  = 16'(PATTERN);
    localparam state_t      S_IDLE   = '0;
    localparam state_t      S_MATCH  = SW'(PAT_LEN);
    // State the detector behaves as after a match, before applying the next bit.
    localparam int          RESTART  = OVERLAP ? border_len(PAT_EXT, PAT_LEN) : 0;

    state_t ps;
    state_t ns;
    state_t ns_accept;

    // Transition table: every entry is a constant produced at elaboration.
    state_t nxt0 [0:PAT_LEN];
    state_t nxt1 [0:PAT_LEN];

    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tbl
        localparam int BASE = (k == PAT_LEN) ? RESTART : k;
        assign nxt0[k] = SW'(kmp_next(PAT_EXT, PAT_LEN, BASE, 1'b0));
        assign nxt1[k] = SW'(kmp_next(PAT_EXT, PAT_LEN, BASE, 1'b1));
    end

    // Present-state register; reset discards any partial pattern progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps <= S_IDLE;
        end else begin
            ps <= ns;
        end
    end

    // Next-state and Mealy output; state only advances on accepted bits.
    always_comb begin
        ns_accept = S_IDLE;
        ns        = ps;
        mealy     = 1'b0;
        if (ps <= S_MATCH) begin
            ns_accept = x_in ? nxt1[ps] : nxt0[ps];
        end
        if (en) begin
            ns = ns_accept;
        end
        mealy = en & ~reset & (ns_accept == S_MATCH);
    end

    assign moore     = (ps == S_MATCH);
    assign state_dbg = ps;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mealy),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm across four parameter sets sharing one stimulus.
module tb_seq_detect_fsm;

    logic clk;
    logic reset;
    logic en;
    logic x_in;

    logic       mealy_a, moore_a;
    logic [7:0] cnt_a;
    logic [2:0] st_a;
    logic       mealy_b, moore_b;
    logic [7:0] cnt_b;
    logic [2:0] st_b;
    logic       mealy_c, moore_c;
    logic [7:0] cnt_c;
    logic [2:0] st_c;
    logic       mealy_d, moore_d;
    logic [1:0] cnt_d;
    logic [2:0] st_d;

    int n_checks;
    int n_errors;

    // 1101, overlapping
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in),
        .mealy(mealy_a), .moore(moore_a), .match_cnt(cnt_a), .state_dbg(st_a));
    // 1101, non-overlapping
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in),
        .mealy(mealy_b), .moore(moore_b), .match_cnt(cnt_b), .state_dbg(st_b));
    // 1111, overlapping
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in),
        .mealy(mealy_c), .moore(moore_c), .match_cnt(cnt_c), .state_dbg(st_c));
    // 1101, overlapping, 2-bit counter
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .en(en), .x_in(x_in),
        .mealy(mealy_d), .moore(moore_d), .match_cnt(cnt_d), .state_dbg(st_d));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous reset pulse with en low.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        x_in  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Present one accepted bit and wait until just after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        en   = 1'b1;
        x_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        x_in  = 1'b1;
        #1;
        n_checks++;
        if (mealy_a !== 1'b0) begin
            $display("FAIL reset_mealy: got %b want 0", mealy_a);
            n_errors++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (st_a !== 3'd0 || st_b !== 3'd0 || st_c !== 3'd0 || st_d !== 3'd0) begin
            $display("FAIL reset_state: got %0d %0d %0d %0d want 0", st_a, st_b, st_c, st_d);
            n_errors++;
        end
        n_checks++;
        if (moore_a !== 1'b0 || moore_c !== 1'b0) begin
            $display("FAIL reset_moore: got %b %b want 0", moore_a, moore_c);
            n_errors++;
        end
        n_checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || cnt_c !== 8'd0 || cnt_d !== 2'd0) begin
            $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", cnt_a, cnt_b, cnt_c, cnt_d);
            n_errors++;
        end
        reset = 1'b0;
        en    = 1'b0;
    endtask

    // Stream 1,1,0,1,1,0,1 into both 1101 detectors (overlap on and off).
    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp_m_a;
        logic [6:0] exp_m_b;
        int         exp_st_a [7];
        int         exp_st_b [7];
        bits     = 7'b1101101;
        exp_m_a  = 7'b0001001;
        exp_m_b  = 7'b0001000;
        exp_st_a = '{1, 2, 3, 4, 2, 3, 4};
        exp_st_b = '{1, 2, 3, 4, 1, 0, 1};
        do_reset();
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            en   = 1'b1;
            x_in = bits[6-j];
            #1;
            n_checks++;
            if (mealy_a !== exp_m_a[6-j] || mealy_b !== exp_m_b[6-j]) begin
                $display("FAIL overlap_mealy bit%0d: got a=%b b=%b want a=%b b=%b",
                         j + 1, mealy_a, mealy_b, exp_m_a[6-j], exp_m_b[6-j]);
                n_errors++;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (moore_a !== exp_m_a[6-j] || moore_b !== exp_m_b[6-j]) begin
                $display("FAIL overlap_moore bit%0d: got a=%b b=%b want a=%b b=%b",
                         j + 1, moore_a, moore_b, exp_m_a[6-j], exp_m_b[6-j]);
                n_errors++;
            end
            n_checks++;
            if (int'(st_a) != exp_st_a[j] || int'(st_b) != exp_st_b[j]) begin
                $display("FAIL overlap_state bit%0d: got a=%0d b=%0d want a=%0d b=%0d",
                         j + 1, st_a, st_b, exp_st_a[j], exp_st_b[j]);
                n_errors++;
            end
        end
        n_checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 8'd1 || cnt_d !== 2'd2) begin
            $display("FAIL overlap_cnt: got a=%0d b=%0d d=%0d want 2 1 2", cnt_a, cnt_b, cnt_d);
            n_errors++;
        end
        en = 1'b0;
    endtask

    // Six consecutive 1s into the 1111 detector.
    task automatic test_all_ones();
        logic [5:0] exp_m;
        int         exp_st [6];
        exp_m  = 6'b000111;
        exp_st = '{1, 2, 3, 4, 4, 4};
        do_reset();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            en   = 1'b1;
            x_in = 1'b1;
            #1;
            n_checks++;
            if (mealy_c !== exp_m[5-j]) begin
                $display("FAIL ones_mealy bit%0d: got %b want %b", j + 1, mealy_c, exp_m[5-j]);
                n_errors++;
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (moore_c !== exp_m[5-j] || int'(st_c) != exp_st[j]) begin
                $display("FAIL ones_moore bit%0d: got moore=%b st=%0d want moore=%b st=%0d",
                         j + 1, moore_c, st_c, exp_m[5-j], exp_st[j]);
                n_errors++;
            end
        end
        n_checks++;
        if (cnt_c !== 8'd3) begin
            $display("FAIL ones_cnt: got %0d want 3", cnt_c);
            n_errors++;
        end
        en = 1'b0;
    endtask

    // 1,1,0,1 with two idle cycles after each bit while x_in toggles.
    task automatic test_en_gating();
        logic [3:0] bits;
        int         exp_st [4];
        bits   = 4'b1101;
        exp_st = '{1, 2, 3, 4};
        do_reset();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            en   = 1'b1;
            x_in = bits[3-j];
            #1;
            n_checks++;
            if (mealy_a !== (j == 3)) begin
                $display("FAIL gate_mealy bit%0d: got %b want %b", j + 1, mealy_a, (j == 3));
                n_errors++;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                en   = 1'b0;
                x_in = ~x_in;
                #1;
                n_checks++;
                if (mealy_a !== 1'b0) begin
                    $display("FAIL gate_idle_mealy bit%0d: got %b want 0", j + 1, mealy_a);
                    n_errors++;
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (int'(st_a) != exp_st[j] || moore_a !== (j == 3)) begin
                    $display("FAIL gate_idle_state bit%0d: got st=%0d moore=%b want st=%0d moore=%b",
                             j + 1, st_a, moore_a, exp_st[j], (j == 3));
                    n_errors++;
                end
            end
        end
        n_checks++;
        if (cnt_a !== 8'd1) begin
            $display("FAIL gate_cnt: got %0d want 1", cnt_a);
            n_errors++;
        end
    endtask

    // Reset after 1,1,0 throws the partial match away.
    task automatic test_reset_mid();
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        n_checks++;
        if (st_a !== 3'd3) begin
            $display("FAIL mid_prefix_state: got %0d want 3", st_a);
            n_errors++;
        end
        do_reset();
        n_checks++;
        if (st_a !== 3'd0 || moore_a !== 1'b0 || cnt_a !== 8'd0) begin
            $display("FAIL mid_after_reset: got st=%0d moore=%b cnt=%0d want 0 0 0", st_a, moore_a, cnt_a);
            n_errors++;
        end
        @(negedge clk);
        en   = 1'b1;
        x_in = 1'b1;
        #1;
        n_checks++;
        if (mealy_a !== 1'b0) begin
            $display("FAIL mid_mealy: got %b want 0", mealy_a);
            n_errors++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (st_a !== 3'd1 || cnt_a !== 8'd0) begin
            $display("FAIL mid_state: got st=%0d cnt=%0d want 1 0", st_a, cnt_a);
            n_errors++;
        end
        en = 1'b0;
    endtask

    // Reset asserted together with the completing bit.
    task automatic test_reset_coincident();
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        en    = 1'b1;
        x_in  = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mealy_a !== 1'b0 || mealy_d !== 1'b0) begin
            $display("FAIL coinc_mealy: got a=%b d=%b want 0", mealy_a, mealy_d);
            n_errors++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        n_checks++;
        if (cnt_a !== 8'd0 || st_a !== 3'd0 || moore_a !== 1'b0) begin
            $display("FAIL coinc_state: got cnt=%0d st=%0d moore=%b want 0 0 0", cnt_a, st_a, moore_a);
            n_errors++;
        end
    endtask

    // Five overlapping matches: 2-bit counter saturates at 3, 8-bit keeps counting.
    task automatic test_saturation();
        logic [1:0] exp_d [5];
        exp_d = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        send_bit(1'b1);
        for (int m = 0; m < 5; m++) begin
            send_bit(1'b1);
            send_bit(1'b0);
            send_bit(1'b1);
            n_checks++;
            if (cnt_d !== exp_d[m] || cnt_a !== 8'(m + 1)) begin
                $display("FAIL sat_cnt match%0d: got d=%0d a=%0d want d=%0d a=%0d",
                         m + 1, cnt_d, cnt_a, exp_d[m], m + 1);
                n_errors++;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        en       = 1'b0;
        x_in     = 1'b0;
        test_reset();
        test_overlap();
        test_all_ones();
        test_en_gating();
        test_reset_mid();
        test_reset_coincident();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
